cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
- Sequencing controller for the two-way set-associative data cache (32-bit words, 3-bit set index, 27-bit tag, LRU replacement with dirty write-back).
- Accepts one CPU load/store at a time, runs the tag lookup, and on a miss sequences an optional dirty-victim write-back followed by a line refill from main memory.
- Replays the access after the refill and returns the result to the CPU.
- Sits between the pipeline memory stage, the cache arrays and the main-memory port.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- OFFSET_WIDTH, 2, byte-offset bits forced to zero on memory addresses

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  access request, sampled only in IDLE
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  ADDR_WIDTH  byte address
- cpu_wdata  input  DATA_WIDTH  store data
- cpu_rdata  output  DATA_WIDTH  load result, valid while cpu_done = 1
- cpu_done  output  1  one-cycle completion pulse
- stall  output  1  pipeline hold
- cache_addr  output  ADDR_WIDTH  latched request address driven to the cache
- cache_hit  input  1  hit in either way for cache_addr
- cache_rdata  input  DATA_WIDTH  hit-way data
- victim_dirty  input  1  LRU victim of the set is valid and dirty
- victim_addr  input  ADDR_WIDTH  victim address {tag, set, 2'b00}
- victim_data  input  DATA_WIDTH  victim data
- cache_we  output  1  one-cycle store-hit write strobe
- cache_wdata  output  DATA_WIDTH  latched store data
- cache_fill  output  1  one-cycle refill strobe; the cache replaces the LRU victim, sets V = 1, clears D
- fill_data  output  DATA_WIDTH  refill word
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1 = write-back, 0 = refill read
- mem_addr  output  ADDR_WIDTH  word-aligned memory address
- mem_wdata  output  DATA_WIDTH  write-back data
- mem_rdata  input  DATA_WIDTH  refill data, valid with mem_ack
- mem_ack  input  1  one-cycle completion from memory

Behaviour:
- The clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset: state = IDLE. All outputs are 0, including cpu_rdata, fill_data and the memory signals. The internal latches clear.
- Reset asserted mid-operation: mem_req drops immediately and the transaction is abandoned. No strobe is emitted.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, FILL, RESP.
- IDLE: on cpu_req = 1, latch cpu_we, cpu_addr (with [1:0] forced to 0) and cpu_wdata, then go to LOOKUP. Without cpu_req, stay in IDLE.
- LOOKUP:
  - Hit and load: capture cache_rdata into cpu_rdata, go to RESP.
  - Hit and store: pulse cache_we with cache_wdata this cycle, go to RESP.
  - Miss: go to WRITEBACK if victim_dirty = 1, otherwise go to REFILL.
- WRITEBACK:
  - On entry, snapshot victim_addr and victim_data.
  - Drive mem_req = 1, mem_we = 1, mem_addr = snapshot address, mem_wdata = snapshot data.
  - Hold all of these stable until mem_ack, then go to REFILL.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = latched address. On mem_ack, register mem_rdata into fill_data and go to FILL.
- FILL: pulse cache_fill for one cycle with fill_data, then go back to LOOKUP (replay). A store then hits and dirties the line (write-allocate).
- A replay that misses again repeats the miss sequence. No error state exists.
- RESP: cpu_done = 1 for exactly one cycle, then go to IDLE. cpu_req is not sampled in RESP, so there is one bubble between back-to-back requests.
- stall is combinational: 1 when (state = IDLE and cpu_req) or when state is in {LOOKUP, WRITEBACK, REFILL, FILL}. It is 0 in RESP and in an idle state with no request.
- mem_ack is ignored outside WRITEBACK and REFILL.
- mem_ack may arrive in the first cycle mem_req is high (zero wait). Memory latency is unbounded.
- Latency from accept edge to cpu_done cycle:
  - hit: 2 cycles
  - clean miss: 5 + refill wait cycles
  - dirty miss: additionally 1 + write-back wait cycles
- cpu_rdata holds its value after RESP until the next load completes.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN
- Defined: adds outputs hit_count, miss_count and wb_count, each 32 bits.
  - hit_count increments on a first-pass LOOKUP hit.
  - miss_count increments on a first-pass LOOKUP miss. Replays are not counted.
  - wb_count increments on each WRITEBACK mem_ack.
  - Counters wrap from 0xFFFFFFFF to 0 and clear on rst_n.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Load 0x40, cache_hit = 1, cache_rdata = 0xDEADBEEF -> cpu_done 2 cycles after accept, cpu_rdata = 0xDEADBEEF, no mem_req.
- Store 0x44 data 0x12345678, hit -> single cache_we pulse with cache_wdata = 0x12345678 in LOOKUP, cpu_done next cycle.
- Load 0x80, miss, victim_dirty = 0, mem_ack after 3 wait cycles with mem_rdata = 0xCAFEF00D -> mem_addr = 0x80 with mem_we = 0, cache_fill with fill_data = 0xCAFEF00D, replay hit, cpu_done.
- Load 0x103, miss, victim_dirty = 1, victim_addr = 0x200, victim_data = 0xAAAA5555 -> mem_we = 1 write of 0xAAAA5555 to 0x200 first, then refill read of 0x100 (offset cleared).
- rst_n low during REFILL with mem_req = 1 -> mem_req, stall and cpu_done = 0 immediately. After release, a new load to 0x40 completes normally.
- With CACHE_PERF_CNT_EN defined, run the four access scenarios above -> hit_count = 2, miss_count = 2, wb_count = 1.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the 2-way data cache: lookup, optional dirty write-back, refill, replay.
// Optional hit/miss/write-back counters are enabled with CACHE_PERF_CNT_EN.
module cache_miss_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  victim_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [DATA_WIDTH-1:0] victim_data,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_fill,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_FILL, S_RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
  logic [DATA_WIDTH-1:0] vdata_q, vdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vaddr_d = vaddr_q;
    vdata_d = vdata_q;
    rdata_d = rdata_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: if (cpu_req) begin
        we_d    = cpu_we;
        addr_d  = cpu_addr & ALIGN_MASK;
        wdata_d = cpu_wdata;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          if (!we_q) rdata_d = cache_rdata;
          state_d = S_RESP;
        end else if (victim_dirty) begin
          // Snapshot the victim now; the cache may change it while memory is busy.
          vaddr_d = victim_addr & ALIGN_MASK;
          vdata_d = victim_data;
          state_d = S_WB;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WB:     if (mem_ack) state_d = S_REFILL;
      S_REFILL: if (mem_ack) begin
        fill_d  = mem_rdata;
        state_d = S_FILL;
      end
      S_FILL:   state_d = S_LOOKUP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
      rdata_q <= rdata_d;
      fill_q  <= fill_d;
    end
  end

  assign cpu_rdata   = rdata_q;
  assign cpu_done    = (state_q == S_RESP);
  assign stall       = ((state_q == S_IDLE) && cpu_req) || (state_q == S_LOOKUP) ||
                       (state_q == S_WB) || (state_q == S_REFILL) || (state_q == S_FILL);
  assign cache_addr  = addr_q;
  assign cache_wdata = wdata_q;
  assign cache_we    = (state_q == S_LOOKUP) && cache_hit && we_q;
  assign cache_fill  = (state_q == S_FILL);
  assign fill_data   = fill_q;
  assign mem_req     = (state_q == S_WB) || (state_q == S_REFILL);
  assign mem_we      = (state_q == S_WB);
  assign mem_addr    = (state_q == S_WB) ? vaddr_q : (state_q == S_REFILL) ? addr_q : '0;
  assign mem_wdata   = (state_q == S_WB) ? vdata_q : '0;

`ifdef CACHE_PERF_CNT_EN
  // replay_q marks the post-refill lookup so it is not counted a second time.
  logic        replay_q, replay_d;
  logic [31:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;

  always_comb begin
    replay_d = replay_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    wb_d     = wb_q;
    if (state_q == S_IDLE && cpu_req) replay_d = 1'b0;
    if (state_q == S_FILL)            replay_d = 1'b1;
    if (state_q == S_LOOKUP && !replay_q) begin
      if (cache_hit) hit_d  = hit_q + 32'd1;
      else           miss_d = miss_q + 32'd1;
    end
    if (state_q == S_WB && mem_ack) wb_d = wb_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      replay_q <= replay_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      wb_q     <= wb_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: the bench plays cache and memory, and predicts each
// transaction's latency, strobes, memory traffic and load result from access outcome.
module tb_cache_miss_ctrl;
  logic        clk, rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, stall;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        victim_dirty;
  logic [31:0] victim_addr, victim_data;
  logic        cache_we;
  logic [31:0] cache_wdata;
  logic        cache_fill;
  logic [31:0] fill_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load = 0;
  int hit_m = 0, miss_m = 0, wb_m = 0;

  cache_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .stall(stall),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .cache_we(cache_we), .cache_wdata(cache_wdata), .cache_fill(cache_fill),
    .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CPU access. The bench answers as cache (hit/victim) and memory (wait states).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hit, input logic dirty, input logic [31:0] vaddr,
                        input logic [31:0] vdata, input logic [31:0] rfval,
                        input logic [31:0] rdval, input int wbw, input int rfw,
                        input string name);
    int n = 0, lat = -1, we_cnt = 0, fill_cnt = 0, wr_acks = 0, rd_acks = 0;
    int sig_err = 0, stall_err = 0, wcnt = 0, tgt, exp_lat;
    logic [31:0] aligned, wedata, fdata, got_rdata, exp_rdata;
    aligned = addr & ~32'h3;
    wedata = 0; fdata = 0; got_rdata = 0;
    cache_hit = hit; cache_rdata = rdval; victim_dirty = dirty;
    victim_addr = vaddr; victim_data = vdata; mem_rdata = rfval; mem_ack = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1 if (stall !== 1'b1) stall_err++;
    @(posedge clk);
    @(negedge clk);
    while (lat < 0 && n < 300) begin
      n++;
      if (cache_addr !== aligned) sig_err++;
      if (cache_we === 1'b1) begin we_cnt++; wedata = cache_wdata; end
      if (cache_fill === 1'b1) begin
        fill_cnt++; fdata = fill_data; cache_hit = 1; cache_rdata = rfval;
      end
      if (mem_req === 1'b1) begin
        if (mem_we === 1'b1) begin
          if (mem_addr !== (vaddr & ~32'h3) || mem_wdata !== vdata) sig_err++;
        end else if (mem_addr !== aligned) sig_err++;
      end
      if (cpu_done === 1'b1) begin
        lat = n; got_rdata = cpu_rdata;
        if (stall !== 1'b0) stall_err++;
      end else if (stall !== 1'b1) stall_err++;
      if (n == 1) begin cpu_req = 0; cpu_addr = $urandom; cpu_wdata = $urandom; end
      if (mem_req === 1'b1) begin
        tgt = mem_we ? wbw : rfw;
        if (wcnt == tgt) begin
          mem_ack = 1; wcnt = 0;
          if (mem_we) wr_acks++; else rd_acks++;
        end else begin
          mem_ack = 0; wcnt++;
        end
      end else mem_ack = 0;
      if (lat < 0) @(negedge clk);
    end
    mem_ack = 0;

    exp_lat   = hit ? 2 : 5 + rfw + (dirty ? 1 + wbw : 0);
    exp_rdata = we ? last_load : (hit ? rdval : rfval);
    if (!we) last_load = exp_rdata;
    if (hit) hit_m++; else begin miss_m++; if (dirty) wb_m++; end

    checks++; if (lat != exp_lat) begin errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++; if (got_rdata !== exp_rdata) begin errors++;
      $display("FAIL %s cpu_rdata: got %h expected %h", name, got_rdata, exp_rdata); end
    checks++; if (we_cnt != (we ? 1 : 0)) begin errors++;
      $display("FAIL %s cache_we pulses: got %0d expected %0d", name, we_cnt, we ? 1 : 0); end
    if (we) begin
      checks++; if (wedata !== wdata) begin errors++;
        $display("FAIL %s cache_wdata: got %h expected %h", name, wedata, wdata); end
    end
    checks++; if (fill_cnt != (hit ? 0 : 1)) begin errors++;
      $display("FAIL %s cache_fill pulses: got %0d expected %0d", name, fill_cnt, hit ? 0 : 1); end
    if (!hit) begin
      checks++; if (fdata !== rfval) begin errors++;
        $display("FAIL %s fill_data: got %h expected %h", name, fdata, rfval); end
    end
    checks++; if (wr_acks != ((!hit && dirty) ? 1 : 0) || rd_acks != (hit ? 0 : 1)) begin
      errors++;
      $display("FAIL %s mem ops: got wb=%0d rd=%0d expected wb=%0d rd=%0d", name, wr_acks,
               rd_acks, (!hit && dirty) ? 1 : 0, hit ? 0 : 1); end
    checks++; if (sig_err != 0) begin errors++;
      $display("FAIL %s address/data signals: got %0d bad cycles expected 0", name, sig_err); end
    checks++; if (stall_err != 0) begin errors++;
      $display("FAIL %s stall: got %0d bad cycles expected 0", name, stall_err); end
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf(input string name);
    checks++;
    if (hit_count !== hit_m || miss_count !== miss_m || wb_count !== wb_m) begin
      errors++;
      $display("FAIL %s counters: got %0d/%0d/%0d expected %0d/%0d/%0d", name, hit_count,
               miss_count, wb_count, hit_m, miss_m, wb_m);
    end
  endtask
`endif

  task automatic test_reset();
    rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cache_hit = 0; cache_rdata = 0; victim_dirty = 0; victim_addr = 0; victim_data = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_rdata, cpu_done, stall, cache_addr, cache_we, cache_wdata, cache_fill, fill_data,
         mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got rdata=%h done=%b stall=%b req=%b addr=%h expected all 0",
               cpu_rdata, cpu_done, stall, mem_req, mem_addr);
    end
    rst_n = 1;
  endtask

  task automatic test_directed();
    do_txn(0, 32'h40, 0, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, "load_hit");
    do_txn(1, 32'h44, 32'h12345678, 1, 0, 0, 0, 0, 32'h0, 0, 0, "store_hit");
    do_txn(0, 32'h80, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h0, 0, 3, "clean_miss");
    do_txn(0, 32'h103, 0, 0, 1, 32'h200, 32'hAAAA5555, 32'h0BADF00D, 0, 2, 1, "dirty_miss");
`ifdef CACHE_PERF_CNT_EN
    test_perf("directed");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      do_txn(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom,
             $urandom, $urandom, $urandom, int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), $sformatf("rand%0d", i));
    do_txn(0, 32'h7C, 0, 0, 1, 32'h3FC, 32'h1, 32'h2, 0, 0, 0, "zero_wait_dirty");
  endtask

  task automatic test_reset_mid();
    cache_hit = 0; victim_dirty = 0; mem_ack = 0;
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
    @(negedge clk); cpu_req = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL midreset refill: got req=%b we=%b addr=%h expected 1 0 00000300",
               mem_req, mem_we, mem_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || cpu_done !== 1'b0 || cache_fill !== 1'b0) begin
      errors++;
      $display("FAIL midreset outputs: got req=%b stall=%b done=%b fill=%b expected 0",
               mem_req, stall, cpu_done, cache_fill);
    end
    @(negedge clk); rst_n = 1;
    last_load = 0; hit_m = 0; miss_m = 0; wb_m = 0;
    do_txn(0, 32'h40, 0, 1, 0, 0, 0, 0, 32'h55AA1234, 0, 0, "after_reset");
`ifdef CACHE_PERF_CNT_EN
    test_perf("after_reset");
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
